pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised N-lane pipeline stage register that generalises the dual-issue inter-stage latches (IF/ID … MEM/WB) into one block. It owns the stage's per-lane valid state and computes its own `now_allowin_o` from `ready_go`/downstream `allowin`, rather than taking `allowin` as an input. Per lane, it loads payload only when that lane is valid. It supports a global exception flush and a per-lane kill for squashing younger lanes, and counts stall cycles for performance analysis. One instance sits between every pair of pipeline stages.

## Interface
Parameters:
- `LANES`, 2, number of issue lanes; lane 0 is the oldest instruction.
- `BUS_W`, 128, payload width per lane.
- `CNT_W`, 32, stall counter width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `pre_to_now_valid_i`  in  LANES  per-lane valid from the previous stage.
- `pre_to_ibus`  in  LANES*BUS_W  payload; lane k at bits [k*BUS_W +: BUS_W].
- `excep_flush_i`  in  1  exception flush; clears all lanes.
- `lane_kill_i`  in  LANES  squashes the held instruction in the selected lanes.
- `now_ready_go_i`  in  1  this stage's combinational work is complete.
- `next_allowin_i`  in  1  next stage can accept data.
- `stall_cnt_clr_i`  in  1  synchronous clear of the stall counter.
- `now_allowin_o`  out  1  this stage accepts data this cycle (combinational).
- `now_valid_o`  out  LANES  registered per-lane valid.
- `now_to_next_valid_o`  out  LANES  per-lane valid presented to the next stage (combinational).
- `to_next_obus`  out  LANES*BUS_W  registered payload.
- `stall_cnt_o`  out  CNT_W  saturating stall-cycle count.

## Operation
- Effective valid is `eff_v = now_valid_o & ~lane_kill_i`.
- `now_allowin_o` = `~|eff_v | (now_ready_go_i & next_allowin_i)`.
- `now_to_next_valid_o` = `eff_v & {LANES{now_ready_go_i}}`.
- Valid update per lane k, in priority order:
  1. If `excep_flush_i`, then 0.
  2. Else if `now_allowin_o`, then `pre_to_now_valid_i[k]`. This applies even if `lane_kill_i[k]` is set; the incoming instruction is never killed.
  3. Else if `lane_kill_i[k]`, then 0.
  4. Else hold.
- Payload update per lane k:
  - Load when `now_allowin_o & pre_to_now_valid_i[k] & ~excep_flush_i`; otherwise hold.
  - A lane with no incoming valid keeps its old payload. Downstream must qualify the payload with valid.
- Stall condition: `|eff_v & ~(now_ready_go_i & next_allowin_i)`.
- Stall counter update, in priority order:
  1. `stall_cnt_clr_i` sets it to 0.
  2. Else, if the stall condition holds, increment, saturating at 2^CNT_W−1.
- `excep_flush_i` does not affect the stall counter.
- Lanes are independent; the block does not enforce lane ordering (for example, a valid lane 1 with an invalid lane 0 is legal).

## Timing
- Reset (async assert, sync release): all `now_valid_o` = 0, `to_next_obus` = 0, `stall_cnt_o` = 0. While `now_valid_o` is 0, `now_allowin_o` = 1.
- Latency: exactly 1 cycle from accepted input to `now_valid_o` / `to_next_obus`.
- Throughput is one group per cycle when `now_ready_go_i` = `next_allowin_i` = 1.
- Flush is visible at the next edge. In the flush cycle, `now_to_next_valid_o` still reflects the held valids; the next stage must also see the flush.
- Kill is visible combinationally the same cycle on `now_to_next_valid_o` and `now_allowin_o`, and takes effect on `now_valid_o` at the next edge.
- Reset asserted mid-stall clears everything immediately; the counter does not resume its old value.
- `now_allowin_o` has no combinational path from `pre_to_now_valid_i` or `pre_to_ibus`.

## Test plan
- **Reset then flow:** `LANES`=2, drive `pre_to_now_valid_i`=2'b11 with payload A=0x11…, B=0x22…; `ready_go`=`next_allowin`=1 → next cycle `now_valid_o`=2'b11 and the bus shows A/B; `stall_cnt_o`=0.
- **Backpressure:** hold valid=2'b11, `next_allowin_i`=0 for 5 cycles → `now_allowin_o`=0, payload held, `stall_cnt_o`=5. Release → a new group loads on the next edge.
- **Per-lane load:** held payload B in lane 1; load valid=2'b01 with A' → lane 0=A', lane 1 bus still B, `now_valid_o`=2'b01.
- **Kill:** stalled with 2'b11, assert `lane_kill_i`=2'b10 for one cycle → `now_to_next_valid_o`[1]=0 that cycle; next cycle `now_valid_o`=2'b01. Repeat with a simultaneous accept → lane 1 takes the new instruction.
- **Flush vs. load:** `excep_flush_i`=1 with incoming valid=2'b11 and allowin=1 → next cycle `now_valid_o`=2'b00, bus unchanged.
- **Saturation and async reset:** `CNT_W`=4, stall 20 cycles → `stall_cnt_o`=15. Drop `rst_n` mid-cycle → outputs go to 0 before the next edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// N-lane inter-stage pipeline register: per-lane valid/payload latches,
// local allowin generation, flush/kill squashing and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned LANES = 2,
    parameter int unsigned BUS_W = 128,
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES-1:0]       pre_to_now_valid_i,
    input  logic [LANES*BUS_W-1:0] pre_to_ibus,
    input  logic                   excep_flush_i,
    input  logic [LANES-1:0]       lane_kill_i,
    input  logic                   now_ready_go_i,
    input  logic                   next_allowin_i,
    input  logic                   stall_cnt_clr_i,
    output logic                   now_allowin_o,
    output logic [LANES-1:0]       now_valid_o,
    output logic [LANES-1:0]       now_to_next_valid_o,
    output logic [LANES*BUS_W-1:0] to_next_obus,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [LANES-1:0] eff_v_c;
    logic             fire_c;
    logic             stall_c;

    // Handshake: allowin depends only on held state and downstream, never on incoming data.
    always_comb begin
        eff_v_c             = now_valid_o & ~lane_kill_i;
        fire_c              = now_ready_go_i & next_allowin_i;
        now_allowin_o       = ~(|eff_v_c) | fire_c;
        now_to_next_valid_o = eff_v_c & {LANES{now_ready_go_i}};
        stall_c             = (|eff_v_c) & ~fire_c;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        // Incoming instructions are never killed; kill only squashes a held one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                now_valid_o[k] <= 1'b0;
            end else if (excep_flush_i) begin
                now_valid_o[k] <= 1'b0;
            end else if (now_allowin_o) begin
                now_valid_o[k] <= pre_to_now_valid_i[k];
            end else if (lane_kill_i[k]) begin
                now_valid_o[k] <= 1'b0;
            end
        end

        // Payload only moves for valid incoming lanes; consumers qualify with valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                to_next_obus[k*BUS_W +: BUS_W] <= '0;
            end else if (now_allowin_o && pre_to_now_valid_i[k] && !excep_flush_i) begin
                to_next_obus[k*BUS_W +: BUS_W] <= pre_to_ibus[k*BUS_W +: BUS_W];
            end
        end
    end

    // Saturating stall-cycle counter for performance analysis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (stall_cnt_clr_i) begin
            stall_cnt_o <= '0;
        end else if (stall_c && (stall_cnt_o != CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule
